sseg_capture: RTL and testbench

//   Reads a multiplexed 7-segment display bus (active-low segments, active-low anodes) and

---
 rtl/sseg_capture.sv | 192 +++++++++++++++++++
 tb/tb_sseg_capture.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/sseg_capture.sv
// Recovers the 5-bit code shown on each digit of a multiplexed, active-low 7-segment bus.
// Inputs are synchronised and debounced; each stable, committed digit produces one update pulse.
module sseg_capture #(
    parameter int NDIG          = 4,
    parameter int STABLE_CYCLES = 8,
    parameter int SYNC_STAGES   = 2,
    localparam int IDXW         = (NDIG > 1) ? $clog2(NDIG) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [6:0]            sseg_in,
    input  logic [NDIG-1:0]       an_in,
    output logic [5*NDIG-1:0]     digits_out,
    output logic [NDIG-1:0]       digit_valid,
    output logic                  upd_pulse,
    output logic [IDXW-1:0]       upd_idx,
    output logic                  err_pulse
);

    localparam int SW = NDIG + 7;
    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] COUNT_MAX    = CW'(STABLE_CYCLES);
    localparam logic [CW-1:0] COUNT_COMMIT = CW'(STABLE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        HOLD   = 2'd2
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [SW-1:0]   sync_q [SYNC_STAGES];
    logic [SW-1:0]   prev_snap;
    logic [SW-1:0]   snap;
    logic [NDIG-1:0] snap_an;
    logic [6:0]      snap_seg;
    logic [CW-1:0]   count_q;
    logic [CW-1:0]   count_d;
    logic            snap_changed;
    logic            an_idle;
    logic            an_onehot;
    logic            do_commit;
    logic [IDXW-1:0] sel_idx;
    logic [4:0]      sel_code;
    logic [4:0]      digit_q [NDIG];

    function automatic logic [4:0] decode(input logic [6:0] seg);
        logic [4:0] code;
        case (seg)
            7'b0000001: code = 5'h00;
            7'b1001111: code = 5'h01;
            7'b0010010: code = 5'h02;
            7'b0000110: code = 5'h03;
            7'b1001100: code = 5'h04;
            7'b0100100: code = 5'h05;
            7'b0100000: code = 5'h06;
            7'b0001111: code = 5'h07;
            7'b0000000: code = 5'h08;
            7'b0000100: code = 5'h09;
            7'b0001000: code = 5'h0A;
            7'b1100000: code = 5'h0B;
            7'b0110001: code = 5'h0C;
            7'b1000010: code = 5'h0D;
            7'b0110000: code = 5'h0E;
            7'b0111000: code = 5'h0F;
            7'b1111111: code = 5'h10;
            default:    code = 5'h1F;
        endcase
        return code;
    endfunction

    // Anodes and segments travel through the synchroniser as one word so a snap is coherent.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '1;
            end
        end else begin
            sync_q[0] <= {an_in, sseg_in};
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign snap         = sync_q[SYNC_STAGES-1];
    assign snap_an      = snap[SW-1:7];
    assign snap_seg     = snap[6:0];
    assign snap_changed = (snap != prev_snap);
    assign an_idle      = &snap_an;
    assign an_onehot    = ($countones(~snap_an) == 1);
    assign sel_code     = decode(snap_seg);

    always_comb begin
        sel_idx = '0;
        for (int i = 0; i < NDIG; i++) begin
            if (!snap_an[i]) begin
                sel_idx = IDXW'(i);
            end
        end
    end

    always_comb begin
        count_d = count_q;
        if (snap_changed) begin
            count_d = '0;
        end else if (count_q != COUNT_MAX) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_snap <= '1;
            count_q   <= '0;
        end else begin
            prev_snap <= snap;
            count_q   <= count_d;
        end
    end

    // The commit decision looks at the count being loaded this edge, so the pulse
    // lands on the same edge the count reaches STABLE_CYCLES-1.
    always_comb begin
        state_d   = state_q;
        do_commit = 1'b0;
        case (state_q)
            IDLE: begin
                if (!an_idle) begin
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                if (an_idle) begin
                    state_d = IDLE;
                end else if (count_d == COUNT_COMMIT) begin
                    do_commit = 1'b1;
                    state_d   = HOLD;
                end
            end
            HOLD: begin
                if (snap_changed) begin
                    state_d = an_idle ? IDLE : SETTLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NDIG; i++) begin
                digit_q[i] <= 5'h10;
            end
            digit_valid <= '0;
            upd_pulse   <= 1'b0;
            upd_idx     <= '0;
            err_pulse   <= 1'b0;
        end else begin
            upd_pulse <= 1'b0;
            err_pulse <= 1'b0;
            if (do_commit) begin
                if (an_onehot) begin
                    digit_q[sel_idx]     <= sel_code;
                    digit_valid[sel_idx] <= 1'b1;
                    upd_pulse            <= 1'b1;
                    upd_idx              <= sel_idx;
                    err_pulse            <= (sel_code == 5'h1F);
                end else begin
                    // Several anodes low at once: flag it, keep every stored digit.
                    err_pulse <= 1'b1;
                end
            end
        end
    end

    for (genvar g = 0; g < NDIG; g++) begin : g_pack
        assign digits_out[5*g +: 5] = digit_q[g];
    end

endmodule

// File: tb/tb_sseg_capture.sv
// Directed bench for sseg_capture: expected commits are queued when stimulus is applied
// and checked, including their cycle of arrival, whenever the DUT pulses.
module tb_sseg_capture;

    logic        clk;
    logic        rst_n;
    logic [6:0]  sseg_in;
    logic [3:0]  an_in;
    logic [19:0] digits_out;
    logic [3:0]  digit_valid;
    logic        upd_pulse;
    logic [1:0]  upd_idx;
    logic        err_pulse;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int t_apply  = 0;

    // Entry layout: [31:16] cycle, [8] upd, [7] err, [6:5] idx, [4:0] code.
    logic [31:0] exp_q[$];

    sseg_capture #(
        .NDIG(4),
        .STABLE_CYCLES(8),
        .SYNC_STAGES(2)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .sseg_in(sseg_in),
        .an_in(an_in),
        .digits_out(digits_out),
        .digit_valid(digit_valid),
        .upd_pulse(upd_pulse),
        .upd_idx(upd_idx),
        .err_pulse(err_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [3:0] an, input logic [6:0] seg);
        @(negedge clk);
        an_in   = an;
        sseg_in = seg;
        t_apply = cyc;
    endtask

    task automatic push(input logic [1:0] idx, input logic [4:0] code, input logic err,
                        input logic upd);
        logic [15:0] t;
        t = 16'(t_apply + 10);
        exp_q.push_back({t, 7'd0, upd, err, idx, code});
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Every pulse must match the head of the expected queue, including its arrival cycle.
    always @(negedge clk) begin
        if (upd_pulse || err_pulse) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_pulse", {30'd0, upd_pulse, err_pulse}, 32'd0);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                chk("pulse_cycle", 32'(cyc[15:0]), 32'(e[31:16]));
                chk("upd_pulse", 32'(upd_pulse), 32'(e[8]));
                chk("err_pulse", 32'(err_pulse), 32'(e[7]));
                if (e[8]) begin
                    chk("upd_idx", 32'(upd_idx), 32'(e[6:5]));
                    chk("commit_code", 32'(digits_out[5*e[6:5] +: 5]), 32'(e[4:0]));
                    chk("commit_valid", 32'(digit_valid[e[6:5]]), 32'd1);
                end
            end
        end
    end

    logic [6:0] scan_seg [4];
    logic [4:0] scan_code [4];

    initial begin
        scan_seg[0] = 7'b0001000; scan_code[0] = 5'h0A;
        scan_seg[1] = 7'b1100000; scan_code[1] = 5'h0B;
        scan_seg[2] = 7'b0110001; scan_code[2] = 5'h0C;
        scan_seg[3] = 7'b1000010; scan_code[3] = 5'h0D;

        rst_n   = 1'b0;
        an_in   = 4'hF;
        sseg_in = 7'h7F;
        wait_cycles(3);
        chk("rst_digits", 32'(digits_out), 32'({4{5'h10}}));
        chk("rst_valid", 32'(digit_valid), 32'd0);
        chk("rst_upd", 32'(upd_pulse), 32'd0);
        chk("rst_err", 32'(err_pulse), 32'd0);
        chk("rst_idx", 32'(upd_idx), 32'd0);

        // Idle bus after reset publishes nothing.
        rst_n = 1'b1;
        wait_cycles(50);
        chk("idle_digits", 32'(digits_out), 32'({4{5'h10}}));
        chk("idle_valid", 32'(digit_valid), 32'd0);

        // Single stable digit 3 on digit 0.
        drive(4'b1110, 7'b0000110);
        push(2'd0, 5'h03, 1'b0, 1'b1);
        wait_cycles(20);
        chk("t2_digit0", 32'(digits_out[4:0]), 32'h03);
        chk("t2_valid", 32'(digit_valid), 32'b0001);

        // A short-lived 2 on digit 1 never commits; the following 4 does.
        drive(4'b1101, 7'b0010010);
        wait_cycles(5);
        drive(4'b1101, 7'b1001100);
        push(2'd1, 5'h04, 1'b0, 1'b1);
        wait_cycles(20);
        chk("t3_digit1", 32'(digits_out[9:5]), 32'h04);
        chk("t3_valid", 32'(digit_valid), 32'b0011);

        // Scan A, b, C, d across the four digits.
        for (int i = 0; i < 4; i++) begin
            logic [3:0] an_v;
            an_v = ~(4'b0001 << i);
            drive(an_v, scan_seg[i]);
            push(2'(i), scan_code[i], 1'b0, 1'b1);
            wait_cycles(15);
        end
        wait_cycles(12);
        chk("t4_digits", 32'(digits_out), 32'({5'h0D, 5'h0C, 5'h0B, 5'h0A}));
        chk("t4_valid", 32'(digit_valid), 32'b1111);

        // Unknown pattern stores 1F with an error; two anodes low only raises an error.
        drive(4'b1011, 7'b1010101);
        push(2'd2, 5'h1F, 1'b1, 1'b1);
        wait_cycles(20);
        chk("t5_digit2", 32'(digits_out[14:10]), 32'h1F);
        drive(4'b1100, 7'b1010101);
        push(2'd0, 5'h00, 1'b1, 1'b0);
        wait_cycles(25);
        chk("t5_digits_kept", 32'(digits_out), 32'({5'h0D, 5'h1F, 5'h0B, 5'h0A}));

        // Reset in the middle of settling, then a full sync+settle period after release.
        drive(4'b1110, 7'b0000000);
        wait_cycles(5);
        rst_n = 1'b0;
        wait_cycles(5);
        chk("t6_rst_digits", 32'(digits_out), 32'({4{5'h10}}));
        chk("t6_rst_valid", 32'(digit_valid), 32'd0);
        chk("t6_rst_idx", 32'(upd_idx), 32'd0);
        chk("t6_rst_pulses", {30'd0, upd_pulse, err_pulse}, 32'd0);
        @(negedge clk);
        rst_n   = 1'b1;
        t_apply = cyc;
        push(2'd0, 5'h08, 1'b0, 1'b1);
        wait_cycles(20);
        chk("t6_digits", 32'(digits_out), 32'({5'h10, 5'h10, 5'h10, 5'h08}));
        chk("t6_valid", 32'(digit_valid), 32'b0001);

        wait_cycles(5);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
